// File: rtl/pixel_streamer.sv
// Raster-order frame source: reads a packed multi-channel image from a 1-cycle-latency
// frame buffer and streams it as frame_start + pixel_valid/pixel_in. Optional PIXEL_STREAMER_CHECKSUM_EN.
module pixel_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_CHANNEL = 3,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int ROW_GAP    = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             hold,
   output logic                             mem_rd_en,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [IN_CHANNEL*DATA_WIDTH-1:0] mem_rdata,
   output logic [IN_CHANNEL*DATA_WIDTH-1:0] pixel_in,
   output logic                             pixel_valid,
   output logic                             frame_start,
   output logic                             frame_done,
`ifdef PIXEL_STREAMER_CHECKSUM_EN
   output logic [15:0]                      checksum,
`endif
   output logic                             busy
);

   localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int GW = $clog2(ROW_GAP + 2);

   typedef enum logic [2:0] {IDLE, SOF, READ, GAP, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic [GW-1:0]   gap_cnt;
   logic            rd_flag;
   logic            x_last, y_last, gap_last;

   assign x_last   = (x == XW'(IMG_WIDTH - 1));
   assign y_last   = (y == YW'(IMG_HEIGHT - 1));
   assign gap_last = (gap_cnt == GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0));

   always_comb begin
      state_nxt   = state;
      mem_rd_en   = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SOF;
         end
         SOF: begin
            frame_start = 1'b1;
            state_nxt   = READ;
         end
         READ: begin
            if (!hold) begin
               mem_rd_en = 1'b1;
               if (x_last) begin
                  if (y_last)           state_nxt = DRAIN;
                  else if (ROW_GAP > 0) state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (gap_last) state_nxt = READ;
         end
         // The final read is still in flight while rd_flag is set; leave once it has landed.
         DRAIN: begin
            if (!rd_flag) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         mem_addr    <= '0;
         gap_cnt     <= '0;
         rd_flag     <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_in    <= '0;
      end else begin
         state       <= state_nxt;
         rd_flag     <= mem_rd_en;
         pixel_valid <= rd_flag;
         if (rd_flag) pixel_in <= mem_rdata;

         if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
         else              gap_cnt <= '0;

         if (state == IDLE && start) begin
            x        <= '0;
            y        <= '0;
            mem_addr <= '0;
         end else if (mem_rd_en) begin
            if (x_last) begin
               x <= '0;
               if (!y_last) y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
            // Address parks on the last pixel instead of wrapping.
            if (!(x_last && y_last)) mem_addr <= mem_addr + ADDR_WIDTH'(1);
         end
      end
   end

`ifdef PIXEL_STREAMER_CHECKSUM_EN
   logic [15:0] sample_sum;

   always_comb begin
      sample_sum = 16'd0;
      for (int ch = 0; ch < IN_CHANNEL; ch++)
         sample_sum = sample_sum + 16'(mem_rdata[ch*DATA_WIDTH +: DATA_WIDTH]);
   end

   always_ff @(posedge clk) begin
      if (rst)                        checksum <= '0;
      else if (state == IDLE && start) checksum <= '0;
      else if (rd_flag)               checksum <= checksum + sample_sum;
   end
`endif

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: 8x8x3 image, one ROW_GAP=0 and one ROW_GAP=2 instance on shared stimulus.
// Per-cycle traces are checked against a directed vector table plus a pixel-order scoreboard.
module tb_pixel_streamer;

   logic clk;
   logic rst, start, hold;

   logic        rd_a, pv_a, fs_a, fd_a, busy_a;
   logic [5:0]  addr_a;
   logic [23:0] rdata_a = '0;
   logic [23:0] pix_a;
   logic [15:0] cs_a;

   logic        rd_g, pv_g, fs_g, fd_g, busy_g;
   logic [5:0]  addr_g;
   logic [23:0] rdata_g = '0;
   logic [23:0] pix_g;
   logic [15:0] cs_g;

   typedef struct {
      logic        fs, pv, fd, busy, rd;
      logic [5:0]  addr;
      logic [23:0] pix;
      logic [15:0] cs;
   } trace_t;

   typedef struct {
      int          test;
      string       name;
      int          cyc;
      logic [4:0]  flags;  // {frame_start, pixel_valid, frame_done, busy, mem_rd_en}
      logic [5:0]  addr;
      logic [23:0] pix;
   } vec_t;

   trace_t      tr[2][256];
   vec_t        vecs[$];
   logic [23:0] exp_q[$];
   int          vidx[64];

   int cyc = 0;
   int t0 = 0;
   int n_checks = 0;
   int n_fail = 0;
   int a_valid, a_first, a_last, a_done, a_fs, a_bad;

   pixel_streamer #(.ROW_GAP(0)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
      .pixel_in(pix_a), .pixel_valid(pv_a), .frame_start(fs_a), .frame_done(fd_a),
`ifdef PIXEL_STREAMER_CHECKSUM_EN
      .checksum(cs_a),
`endif
      .busy(busy_a)
   );

   pixel_streamer #(.ROW_GAP(2)) dut_g (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .mem_rd_en(rd_g), .mem_addr(addr_g), .mem_rdata(rdata_g),
      .pixel_in(pix_g), .pixel_valid(pv_g), .frame_start(fs_g), .frame_done(fd_g),
`ifdef PIXEL_STREAMER_CHECKSUM_EN
      .checksum(cs_g),
`endif
      .busy(busy_g)
   );

`ifndef PIXEL_STREAMER_CHECKSUM_EN
   assign cs_a = '0;
   assign cs_g = '0;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Image value (ch+1)*10 + y*8 + x == (ch+1)*10 + addr.
   function automatic logic [23:0] pix_of(input int p);
      logic [7:0] c0, c1, c2;
      c0 = 8'(10 + p);
      c1 = 8'(20 + p);
      c2 = 8'(30 + p);
      return {c2, c1, c0};
   endfunction

   always @(posedge clk) begin
      if (rd_a) rdata_a <= pix_of(int'(addr_a));
      if (rd_g) rdata_g <= pix_of(int'(addr_g));
   end

   always @(negedge clk) begin
      if (cyc - t0 >= 0 && cyc - t0 < 256) begin
         tr[0][cyc - t0] <= '{fs_a, pv_a, fd_a, busy_a, rd_a, addr_a, pix_a, cs_a};
         tr[1][cyc - t0] <= '{fs_g, pv_g, fd_g, busy_g, rd_g, addr_g, pix_g, cs_g};
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_vecs(input int test);
      trace_t t;
      foreach (vecs[i]) begin
         if (vecs[i].test == test) begin
            t = tr[0][vecs[i].cyc];
            check(vecs[i].name, 64'({t.fs, t.pv, t.fd, t.busy, t.rd, t.addr, t.pix}),
                  64'({vecs[i].flags, vecs[i].addr, vecs[i].pix}));
         end
      end
   endtask

   // Scoreboard over the trace of the current run: raster-order pixels, markers, timing.
   task automatic analyze(input int u);
      int lim;
      trace_t t;
      logic [23:0] e;
      lim = cyc - t0;
      if (lim > 256) lim = 256;
      a_valid = 0; a_first = -1; a_last = -1; a_done = -1; a_fs = 0; a_bad = 0;
      for (int k = 0; k < 64; k++) vidx[k] = -1;
      exp_q.delete();
      for (int p = 0; p < 64; p++) exp_q.push_back(pix_of(p));
      for (int i = 0; i < lim; i++) begin
         t = tr[u][i];
         if (t.fs) a_fs++;
         if (t.fs && t.pv) a_bad++;
         if (t.fd && a_done < 0) a_done = i;
         if (t.pv) begin
            if (a_first < 0) a_first = i;
            a_last = i;
            if (a_valid < 64) vidx[a_valid] = i;
            a_valid++;
            if (exp_q.size() == 0) a_bad++;
            else begin
               e = exp_q.pop_front();
               if (e !== t.pix) a_bad++;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_frame(input int hold_at, input int hold_len, input int stray_at,
                            input int rst_at, output int done_rel);
      done_rel = -1;
      @(posedge clk); #1;
      t0 = cyc;
      for (int rel = 0; rel < 300; rel++) begin
         if (rel > 0) begin
            @(posedge clk); #1;
         end
         start = (rel == 0) || (rel == stray_at);
         hold  = (rel >= hold_at) && (rel < hold_at + hold_len);
         rst   = (rel == rst_at);
         @(negedge clk);
         if (rel == rst_at) begin
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0; hold = 1'b0;
            return;
         end
         if (fd_a) begin
            done_rel = rel;
            break;
         end
      end
      start = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int d, gap_bad, step;

      vecs.push_back('{1, "t1_idle0",   0,  5'b00000, 6'd0,  24'h000000});
      vecs.push_back('{1, "t1_sof",     1,  5'b10010, 6'd0,  24'h000000});
      vecs.push_back('{1, "t1_rd0",     2,  5'b00011, 6'd0,  24'h000000});
      vecs.push_back('{1, "t1_rd1",     3,  5'b00011, 6'd1,  24'h000000});
      vecs.push_back('{1, "t1_pix0",    4,  5'b01011, 6'd2,  24'h1E140A});
      vecs.push_back('{1, "t1_pix6",    10, 5'b01011, 6'd8,  24'h241A10});
      vecs.push_back('{1, "t1_lastrd",  65, 5'b01011, 6'd63, 24'h5B5147});
      vecs.push_back('{1, "t1_drain",   66, 5'b01010, 6'd63, 24'h5C5248});
      vecs.push_back('{1, "t1_pix63",   67, 5'b01010, 6'd63, 24'h5D5349});
      vecs.push_back('{1, "t1_done",    68, 5'b00110, 6'd63, 24'h5D5349});
      vecs.push_back('{1, "t1_idle",    69, 5'b00000, 6'd63, 24'h5D5349});
      vecs.push_back('{2, "t2_hold0",   22, 5'b01010, 6'd20, 24'h30261C});
      vecs.push_back('{2, "t2_hold1",   23, 5'b01010, 6'd20, 24'h31271D});
      vecs.push_back('{2, "t2_bubble",  24, 5'b00010, 6'd20, 24'h31271D});
      vecs.push_back('{2, "t2_resume",  26, 5'b00011, 6'd21, 24'h31271D});
      vecs.push_back('{2, "t2_pix20",   27, 5'b01011, 6'd22, 24'h32281E});
      vecs.push_back('{2, "t2_done",    71, 5'b00110, 6'd63, 24'h5D5349});
      vecs.push_back('{3, "t3_accept",  0,  5'b00000, 6'd63, 24'h5D5349});
      vecs.push_back('{3, "t3_sof",     1,  5'b10010, 6'd0,  24'h5D5349});
      vecs.push_back('{4, "t4_pix30",   34, 5'b01011, 6'd32, 24'h3C3228});
      vecs.push_back('{4, "t4_reset",   35, 5'b00000, 6'd0,  24'h000000});
      vecs.push_back('{4, "t4_idle",    40, 5'b00000, 6'd0,  24'h000000});
      vecs.push_back('{5, "t5_rd0",     2,  5'b00011, 6'd0,  24'h000000});
      vecs.push_back('{5, "t5_pix0",    4,  5'b01011, 6'd2,  24'h1E140A});

      rst = 1'b1; start = 1'b0; hold = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'({fs_a, pv_a, fd_a, busy_a, rd_a, addr_a, pix_a, cs_a}), 64'(0));
      check("reset_outputs_g", 64'({fs_g, pv_g, fd_g, busy_g, rd_g, addr_g, pix_g, cs_g}), 64'(0));
      @(negedge clk);
      check("rst_beats_start", 64'({fs_a, busy_a}), 64'(0));

      // Unstalled frame on both instances.
      run_frame(-1, 0, -1, -1, d);
      idle_cycles(20);
      check("t1_done_cycle", 64'(d), 64'(68));
      apply_vecs(1);
      analyze(0);
      check("t1_n_valid", 64'(a_valid), 64'(64));
      check("t1_first_valid", 64'(a_first), 64'(4));
      check("t1_last_valid", 64'(a_last), 64'(67));
      check("t1_order", 64'(a_bad), 64'(0));
`ifdef PIXEL_STREAMER_CHECKSUM_EN
      check("t1_checksum", 64'(tr[0][68].cs), 64'(16'd9888));
`endif
      analyze(1);
      check("gap_done_cycle", 64'(a_done), 64'(82));
      check("gap_n_valid", 64'(a_valid), 64'(64));
      check("gap_order", 64'(a_bad), 64'(0));
      check("gap_row1_first", 64'(vidx[8]), 64'(14));
      gap_bad = 0;
      for (int k = 0; k < 63; k++) begin
         step = (k % 8 == 7) ? 3 : 1;
         if (vidx[k + 1] - vidx[k] != step) gap_bad++;
      end
      check("gap_spacing", 64'(gap_bad), 64'(0));

      // Three hold cycles while the read of pixel 20 is pending.
      run_frame(22, 3, -1, -1, d);
      idle_cycles(2);
      check("t2_done_cycle", 64'(d), 64'(71));
      apply_vecs(2);
      analyze(0);
      check("t2_n_valid", 64'(a_valid), 64'(64));
      check("t2_order", 64'(a_bad), 64'(0));

      // Stray start mid-frame, then back-to-back start right after DONE.
      run_frame(-1, 0, 10, -1, d);
      analyze(0);
      check("t3_done_cycle", 64'(d), 64'(68));
      check("t3_single_sof", 64'(a_fs), 64'(1));
      check("t3_n_valid", 64'(a_valid), 64'(64));
      run_frame(-1, 0, -1, -1, d);
      idle_cycles(1);
      check("t3b_done_cycle", 64'(d), 64'(68));
      apply_vecs(3);
`ifdef PIXEL_STREAMER_CHECKSUM_EN
      check("t3_checksum_clr", 64'(tr[0][1].cs), 64'(0));
      check("t3_checksum", 64'(tr[0][68].cs), 64'(16'd9888));
`endif

      // Reset while pixel 30 is on the output, then a clean restart.
      run_frame(-1, 0, -1, 34, d);
      idle_cycles(10);
      apply_vecs(4);
      analyze(0);
      check("t4_pixels_before_rst", 64'(a_valid), 64'(31));
      check("t4_order", 64'(a_bad), 64'(0));
      check("t4_no_done", 64'(a_done), 64'(-1));
`ifdef PIXEL_STREAMER_CHECKSUM_EN
      check("t4_checksum_rst", 64'(tr[0][35].cs), 64'(0));
`endif
      run_frame(-1, 0, -1, -1, d);
      idle_cycles(2);
      check("t5_done_cycle", 64'(d), 64'(68));
      apply_vecs(5);
      analyze(0);
      check("t5_n_valid", 64'(a_valid), 64'(64));
      check("t5_order", 64'(a_bad), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_streamer.md
# pixel_streamer

- Frame source that feeds the convolution layer.
- Reads a multi-channel image from a single-port frame buffer in raster order and sends it on the layer's pixel input interface (`frame_start`, `pixel_in`, `pixel_valid`).
- Timing follows the layer's input protocol: a one-cycle frame marker, then `IMG_WIDTH*IMG_HEIGHT` packed pixels, with optional inter-row gaps and upstream hold.

## Interface

- `DATA_WIDTH`, 8: bits per channel sample.
- `IN_CHANNEL`, 3: channels packed per pixel.
- `IMG_WIDTH`, 8: pixels per row.
- `IMG_HEIGHT`, 8: rows per frame.
- `ADDR_WIDTH`, 6: frame-buffer address width; `2**ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT`.
- `ROW_GAP`, 0: idle read cycles inserted after each row except the last.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `hold`  in  1  suppresses issuing a frame-buffer read this cycle.
- `mem_rd_en`  out  1  frame-buffer read strobe.
- `mem_addr`  out  ADDR_WIDTH  read address, `y*IMG_WIDTH + x`.
- `mem_rdata`  in  IN_CHANNEL*DATA_WIDTH  read data, valid exactly 1 cycle after `mem_rd_en`.
- `pixel_in`  out  IN_CHANNEL*DATA_WIDTH  packed pixel; channel ch at `[(ch+1)*DATA_WIDTH-1 -: DATA_WIDTH]`.
- `pixel_valid`  out  1  `pixel_in` carries a pixel this cycle.
- `frame_start`  out  1  one-cycle frame marker.
- `frame_done`  out  1  one-cycle pulse after the last pixel.
- `busy`  out  1  frame in progress.
- `checksum`  out  16  present only with `PIXEL_STREAMER_CHECKSUM_EN`.

## Operation

- **States:** IDLE, SOF, READ, GAP, DRAIN, DONE.
- **IDLE → SOF:** on `start`. `start` in any other state is ignored.
- **SOF:** lasts exactly one cycle, drives `frame_start=1`, issues no read. Next state is READ.
- **READ:**
  - Each cycle with `hold=0`: `mem_rd_en=1` at the current (x,y), then x advances; at x wraps to 0 and y increments.
  - Cycle with `hold=1`: `mem_rd_en=0`, counters unchanged.
  - After the read at x=`IMG_WIDTH-1`, y<`IMG_HEIGHT-1`: go to GAP if `ROW_GAP>0`, otherwise stay in READ.
- **GAP:** counts `ROW_GAP` cycles with no reads, then returns to READ. `hold` does not extend GAP.
- **After the final read (last pixel):** go to DRAIN. DRAIN waits until that final pixel has been output.
- **DONE:** one cycle with `frame_done=1`, then IDLE.
- **Data path:** a read-return flag delayed by one cycle from `mem_rd_en`. When the flag is set, `mem_rdata` is registered into `pixel_in` and `pixel_valid=1` on the following cycle.
  - Every issued read yields exactly one pixel. There is no reordering.
  - `pixel_in` holds its last value while `pixel_valid=0`.
- **Address:** an incrementing counter, 0 .. `IMG_WIDTH*IMG_HEIGHT-1`. It never wraps within a frame and resets to 0 at SOF.
- `frame_start` and `pixel_valid` are never high in the same cycle.
- **Reset:**
  - All outputs are 0 in the cycle after `rst`. This covers `pixel_in`, `mem_addr`, `checksum` and every strobe.
  - State returns to IDLE; in-flight read data is discarded.
  - Reset mid-frame emits no `frame_done`.
  - `rst` wins over a simultaneous `start`.

## Timing

- **Unstalled frame:**
  - `start` sampled in cycle 0.
  - `frame_start` in cycle 1.
  - First `mem_rd_en` in cycle 2.
  - First `pixel_valid` in cycle 4.
- **Start-to-first-pixel latency:** 4 cycles. Read-to-pixel latency is 2 cycles.
- **With `hold=0`, `ROW_GAP=0`:** `pixel_valid` is high for `IMG_WIDTH*IMG_HEIGHT` consecutive cycles.
- **With `ROW_GAP=G`:** exactly G invalid cycles between the last pixel of row y and the first pixel of row y+1.
- Each `hold` cycle during READ inserts exactly one invalid cycle, 2 cycles later.
- **`frame_done`:** the cycle immediately after the last `pixel_valid`.
- **`busy`:** high from the SOF cycle through the DONE cycle inclusive. A new `start` is accepted the cycle after DONE.

## Configuration

- **`PIXEL_STREAMER_CHECKSUM_EN` defined:**
  - `checksum` port and logic are present.
  - Accumulates the unsigned sum, mod 2^16, of every channel sample of every emitted pixel.
  - Cleared to 0 at SOF.
  - Final value is valid and stable from the DONE cycle until the next SOF.
- **Not defined:** no `checksum` port, no accumulator.

## Test plan

All scenarios use the frame-buffer model with 1-cycle latency and image value `(ch+1)*10 + y*8 + x`, 8x8x3.

- **Unstalled frame, `ROW_GAP=0`:** `frame_start` at cycle 1, 64 consecutive `pixel_valid` at cycles 4–67, `frame_done` at 68. First pixel `{30,20,10}` (ch2..ch0), last pixel `{93,83,73}`.
- **`ROW_GAP=2`:** exactly 2 invalid cycles after each of rows 0–6. 64 pixels in raster order. `frame_done` at cycle 82.
- **`hold` high for 3 cycles mid-row (read of pixel 20 pending):** exactly 3 invalid output cycles. Pixel 20 follows pixel 19 with no loss or duplication.
- **`start` pulsed during busy:** ignored, single frame only. `start` the cycle after DONE: second `frame_start` 1 cycle later.
- **`rst` asserted at pixel 30:** next cycle all outputs 0, state IDLE, no `frame_done`. A subsequent `start` streams the full frame from address 0.
- **With `PIXEL_STREAMER_CHECKSUM_EN`:** `checksum` = 9888 (0x26A0) at `frame_done`. It clears to 0 at the next SOF.
